// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B.
// Operands are consumed LSB first, one bit per clock, through a single
// registered full-subtractor cell. The borrow flop carries between bits.
// Handshake: start_in is accepted in IDLE or DONE. done_out pulses for one cycle.
// Optional feature macro: SERIAL_SUB_SIGNED_OVF_EN adds ovf_out, the signed
// overflow of A - B.
`timescale 1ns/1ps

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] d_out,
  output logic             b_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;      // minuend shift register
  logic [WIDTH-1:0] b_sh;      // subtrahend shift register
  logic [WIDTH-2:0] res;       // partial result, upper WIDTH-1 bits so far
  logic [WIDTH-1:0] res_next;  // result register after this cycle's bit
  logic [CNT_W-1:0] cnt;       // index of the bit being processed
  logic             bw;        // borrow into the current bit

  logic             accept;
  logic             last_bit;
  logic             diff;
  logic             bw_next;

  // Full-subtractor cell on the operand LSBs and the stored borrow.
  always_comb begin
    diff     = a_sh[0] ^ b_sh[0] ^ bw;
    bw_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    res_next = {diff, res};
    accept   = start_in && ((state == IDLE) || (state == DONE));
    last_bit = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of the order of the statements.
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (start_in) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start_in ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded directly from the state.
  always_comb begin
    busy_out = (state == SHIFT);
    done_out = (state == DONE);
  end

  // Operand capture, serial datapath and the counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: the operand and result registers are cleared as well. After reset
    // the block is in a known state, not only its visible outputs.
    if (rst_in) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
      bw   <= 1'b0;
    end else if (accept) begin
      a_sh <= a_in;
      b_sh <= b_in;
      res  <= '0;
      cnt  <= '0;
      bw   <= 1'b0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_next[WIDTH-1:1];
      cnt  <= cnt + CNT_W'(1);
      bw   <= bw_next;
    end
  end

  // Result outputs load on entry to DONE and hold until the next result.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      d_out <= '0;
      b_out <= 1'b0;
    end else if (last_bit) begin
      d_out <= res_next;
      b_out <= bw_next;
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // Signed overflow: the borrow into the MSB differs from the borrow out of it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovf_out <= 1'b0;
    end else if (last_bit) begin
      ovf_out <= bw ^ bw_next;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH = 8) using a scoreboard.
// Expected results are pushed when a start is accepted. The monitor pops and
// compares them on every done_out pulse. Between pulses it checks that
// d_out and b_out hold the last result.
`timescale 1ns/1ps

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] d_out;
  logic             b_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_out;
`endif

  int               n_checks = 0;
  int               n_errors = 0;
  exp_t             sb_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] last_d = '0;
  logic             last_b = 1'b0;
  logic             last_ovf = 1'b0;
  logic             prev_done = 1'b0;
  int               done_count = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (start_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .d_out    (d_out),
    .b_out    (b_out)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: wide unsigned subtraction plus a sign-based overflow rule.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t             m;
    logic [WIDTH:0]   wide;
    wide  = {1'b0, a} - {1'b0, b};
    m.d   = wide[WIDTH-1:0];
    m.bo  = wide[WIDTH];
    m.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (m.d[WIDTH-1] != a[WIDTH-1]);
    return m;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic bo, input logic ovf);
    exp_t e;
    e.d   = d;
    e.bo  = bo;
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // Monitor: result checks on done_out, hold checks on every other cycle.
  always @(negedge clk_in) begin
    if (rst_in) begin
      last_d    = '0;
      last_b    = 1'b0;
      last_ovf  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done_out) begin
        done_count++;
        check("done_single_cycle", 32'(prev_done), 32'(0));
        check("busy_in_done", 32'(busy_out), 32'(0));
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("d_out", 32'(d_out), 32'(mon_e.d));
          check("b_out", 32'(b_out), 32'(mon_e.bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          check("ovf_out", 32'(ovf_out), 32'(mon_e.ovf));
`endif
          last_d   = mon_e.d;
          last_b   = mon_e.bo;
          last_ovf = mon_e.ovf;
        end
      end else begin
        check("d_hold", 32'(d_out), 32'(last_d));
        check("b_hold", 32'(b_out), 32'(last_b));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("ovf_hold", 32'(ovf_out), 32'(last_ovf));
`endif
      end
      prev_done = done_out;
    end
  end

  // Wait for done_out. The first negedge after the accepting edge counts as 1.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      cycles++;
      if (done_out) return;
    end
    check("done_timeout", 32'(0), 32'(1));
  endtask

  // One operation from idle. The operands are scrambled after capture.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] d, input logic bo, input logic ovf);
    int cyc;
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = a;
    b_in     = b;
    push_exp(d, bo, ovf);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    a_in     = WIDTH'($urandom);
    b_in     = WIDTH'($urandom);
    wait_done(cyc);
    check("latency", 32'(cyc), 32'(WIDTH + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   d0;
    exp_t m;

    rst_in   = 1'b1;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", 32'(busy_out), 32'(0));
    check("rst_done", 32'(done_out), 32'(0));
    check("rst_d", 32'(d_out), 32'(0));
    check("rst_b", 32'(b_out), 32'(0));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf_out), 32'(0));
`endif
    rst_in = 1'b0;

    // Directed cases with hand-computed results.
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Random operands checked against the model.
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      m  = model(ra, rb);
      run_op(ra, rb, m.d, m.bo, m.ovf);
    end

    // A start during SHIFT is ignored: one done_out, operands not re-captured.
    @(negedge clk_in);
    d0       = done_count;
    start_in = 1'b1;
    a_in     = 8'h10;
    b_in     = 8'h01;
    push_exp(8'h0F, 1'b0, 1'b0);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (2) @(negedge clk_in);
    start_in = 1'b1;
    a_in     = 8'hAA;
    b_in     = 8'h55;
    repeat (3) @(negedge clk_in);
    start_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check("mid_shift_start_dones", 32'(done_count - d0), 32'(1));

    // Back-to-back: start stays high through DONE with the next operands queued.
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = 8'h10;
    b_in     = 8'h01;
    push_exp(8'h0F, 1'b0, 1'b0);
    @(posedge clk_in);
    #1;
    a_in = 8'h20;
    b_in = 8'h30;
    wait_done(cyc);
    check("b2b_first_latency", 32'(cyc), 32'(WIDTH + 1));
    #1;
    push_exp(8'hF0, 1'b1, 1'b0);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    wait_done(cyc);
    check("b2b_second_latency", 32'(cyc), 32'(WIDTH + 1));

    // Asynchronous reset four cycles into SHIFT discards the operation.
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = 8'h5A;
    b_in     = 8'h21;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2;
    d0     = done_count;
    rst_in = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy_out), 32'(0));
    check("async_rst_done", 32'(done_out), 32'(0));
    check("async_rst_d", 32'(d_out), 32'(0));
    check("async_rst_b", 32'(b_out), 32'(0));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("async_rst_ovf", 32'(ovf_out), 32'(0));
`endif
    repeat (2) @(negedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check("dones_after_reset", 32'(done_count - d0), 32'(0));

    // Recovery after reset.
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk_in);
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
